// File: rtl/clkdiv_pkg.sv
// -----------------------------------------------------------------------------
// clkdiv_pkg
// Shared constants, types and helpers for the programmable clock divider.
//   CNT_W_DEFAULT : default width of the divide ratio and period counter
//   div_t         : ratio/counter type at the default width
//   half_ceil(n)  : ceil(n/2), the number of low cycles of out_clk for ratio n
//   sanitize(n)   : maps a requested ratio of 0 onto 1
// -----------------------------------------------------------------------------
package clkdiv_pkg;

  localparam int CNT_W_DEFAULT = 8;

  typedef logic [CNT_W_DEFAULT-1:0] div_t;

  // Helpers work on 32 bits so they can serve any parameterised width;
  // callers cast the result back to their own width.
  function automatic logic [31:0] half_ceil(input logic [31:0] n);
    return (n + 32'd1) >> 1;
  endfunction

  function automatic logic [31:0] sanitize(input logic [31:0] n);
    return (n == 32'd0) ? 32'd1 : n;
  endfunction

endpackage

// File: rtl/clkdiv_ratio_shadow.sv
// -----------------------------------------------------------------------------
// clkdiv_ratio_shadow
// Holds the active divide ratio plus a one-deep shadow of a requested ratio.
// A new ratio only becomes active on an apply strobe (period wrap or
// synchronous clear), so a running period is never cut short or stretched.
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   apply         period boundary this cycle (wrap edge or sync_clr)
//   div_load      strobe: capture div_val as the requested ratio
//   div_val       requested ratio (0 treated as 1)
//   cur_div       active ratio (registered)
//   cur_div_next  value cur_div takes at the coming edge
//   load_ack      one-cycle pulse in the first cycle a new ratio is active
// -----------------------------------------------------------------------------
module clkdiv_ratio_shadow
  import clkdiv_pkg::*;
#(
  parameter int CNT_W     = CNT_W_DEFAULT,
  parameter int DIV_RESET = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             apply,
  input  logic             div_load,
  input  logic [CNT_W-1:0] div_val,
  output logic [CNT_W-1:0] cur_div,
  output logic [CNT_W-1:0] cur_div_next,
  output logic             load_ack
);

  logic [CNT_W-1:0] shadow_reg;
  logic [CNT_W-1:0] shadow_next;
  logic [CNT_W-1:0] load_val;
  logic             pending_reg;
  logic             pending_next;
  logic             ack_next;

  assign load_val = CNT_W'(sanitize(32'(div_val)));

  always_comb begin
    shadow_next  = shadow_reg;
    pending_next = pending_reg;
    cur_div_next = cur_div;
    ack_next     = 1'b0;
    if (apply) begin
      // A load arriving in the boundary cycle itself skips the shadow and
      // wins over anything already pending.
      if (div_load) begin
        cur_div_next = load_val;
        pending_next = 1'b0;
        ack_next     = 1'b1;
      end else if (pending_reg) begin
        cur_div_next = shadow_reg;
        pending_next = 1'b0;
        ack_next     = 1'b1;
      end
    end else if (div_load) begin
      // Last load before the boundary wins; still only one ack.
      shadow_next  = load_val;
      pending_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_div     <= CNT_W'(DIV_RESET);
      shadow_reg  <= CNT_W'(DIV_RESET);
      pending_reg <= 1'b0;
      load_ack    <= 1'b0;
    end else begin
      cur_div     <= cur_div_next;
      shadow_reg  <= shadow_next;
      pending_reg <= pending_next;
      load_ack    <= ack_next;
    end
  end

endmodule

// File: rtl/programmable_clock_divider.sv
// -----------------------------------------------------------------------------
// programmable_clock_divider
// Run-time programmable integer clock divider producing a divided
// clock-enable waveform and a one-cycle end-of-period tick.
// Ports:
//   clk       clock
//   rst       asynchronous active-low reset
//   en        1 = count; 0 = freeze counter and out_clk, tick forced low
//   sync_clr  restart the current period (priority over en and loads)
//   div_val   requested ratio (0 treated as 1), sampled with div_load
//   div_load  strobe capturing div_val into the shadow register
//   load_ack  one-cycle pulse when a new ratio becomes active
//   cur_div   active ratio N
//   out_clk   divided waveform: low ceil(N/2) cycles, high floor(N/2)
//   tick      high during the last cycle of each period
// -----------------------------------------------------------------------------
module programmable_clock_divider
  import clkdiv_pkg::*;
#(
  parameter int CNT_W     = CNT_W_DEFAULT,
  parameter int DIV_RESET = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sync_clr,
  input  logic [CNT_W-1:0] div_val,
  input  logic             div_load,
  output logic             load_ack,
  output logic [CNT_W-1:0] cur_div,
  output logic             out_clk,
  output logic             tick
);

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic [CNT_W-1:0] cur_div_next;
  logic             wrap;
  logic             apply;
  logic             out_clk_next;
  logic             tick_next;

  // cur_div is always >= 1, so the subtraction cannot underflow.
  assign wrap  = en && (cnt_reg == cur_div - CNT_W'(1));
  assign apply = sync_clr || wrap;

  clkdiv_ratio_shadow #(
    .CNT_W     (CNT_W),
    .DIV_RESET (DIV_RESET)
  ) u_shadow (
    .clk          (clk),
    .rst          (rst),
    .apply        (apply),
    .div_load     (div_load),
    .div_val      (div_val),
    .cur_div      (cur_div),
    .cur_div_next (cur_div_next),
    .load_ack     (load_ack)
  );

  always_comb begin
    cnt_next = cnt_reg;
    if (sync_clr) begin
      cnt_next = '0;
    end else if (en) begin
      cnt_next = wrap ? '0 : cnt_reg + CNT_W'(1);
    end
  end

  // Outputs are computed from the counter and ratio that will be live after
  // the edge, so the registered outputs line up with the registered count.
  always_comb begin
    out_clk_next = (32'(cnt_next) >= half_ceil(32'(cur_div_next)));
    tick_next    = en && !sync_clr && (cnt_next == cur_div_next - CNT_W'(1));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg <= '0;
      out_clk <= 1'b0;
      tick    <= 1'b0;
    end else begin
      cnt_reg <= cnt_next;
      out_clk <= out_clk_next;
      tick    <= tick_next;
    end
  end

endmodule

// File: tb/tb_programmable_clock_divider.sv
// -----------------------------------------------------------------------------
// tb_programmable_clock_divider
// Directed bench for programmable_clock_divider. A period/phase model of the
// divider is compared against the DUT every cycle, and literal waveforms
// worked out by hand pin the model at key points.
// -----------------------------------------------------------------------------
module tb_programmable_clock_divider;

  logic       clk;
  logic       rst;
  logic       en;
  logic       sync_clr;
  logic [7:0] div_val;
  logic       div_load;
  logic       load_ack;
  logic [7:0] cur_div;
  logic       out_clk;
  logic       tick;

  int errors = 0;
  int checks = 0;
  bit chk_on = 0;

  programmable_clock_divider #(
    .CNT_W     (8),
    .DIV_RESET (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .sync_clr (sync_clr),
    .div_val  (div_val),
    .div_load (div_load),
    .load_ack (load_ack),
    .cur_div  (cur_div),
    .out_clk  (out_clk),
    .tick     (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model: position within the period and ratio ----------
  typedef struct {
    int pos;     // cycles elapsed in the current period
    int n;       // active ratio
    bit pend;    // a requested ratio is waiting for a boundary
    int shadow;  // the requested ratio
    bit ack;     // a ratio became active at the last edge
    bit tick;    // last edge advanced into the final cycle of a period
  } mstate_t;

  mstate_t m;

  function automatic mstate_t model_reset();
    mstate_t r;
    r.pos = 0; r.n = 2; r.pend = 0; r.shadow = 2; r.ack = 0; r.tick = 0;
    return r;
  endfunction

  function automatic mstate_t model_step(input mstate_t s, input bit e, input bit clr,
                                         input bit ld, input int dv);
    mstate_t r;
    int v;
    bit boundary;
    r = s;
    v = (dv == 0) ? 1 : dv;
    boundary = clr || (e && (s.pos == s.n - 1));
    r.ack = 0;
    if (clr)    r.pos = 0;
    else if (e) r.pos = (s.pos + 1) % s.n;
    if (boundary && (ld || s.pend)) begin
      r.n = ld ? v : s.shadow;
      r.pend = 0;
      r.ack = 1;
    end else if (ld) begin
      r.shadow = v;
      r.pend = 1;
    end
    r.tick = e && !clr && (r.pos == r.n - 1);
    return r;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) m <= model_reset();
    else      m <= model_step(m, en, sync_clr, div_load, int'(div_val));
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- per-cycle compare against the model -------------------
  always @(negedge clk) begin
    if (chk_on) begin
      check("cyc_out_clk", int'(out_clk), (m.pos >= (m.n + 1) / 2) ? 1 : 0);
      check("cyc_tick", int'(tick), int'(m.tick));
      check("cyc_load_ack", int'(load_ack), int'(m.ack));
      check("cyc_cur_div", int'(cur_div), m.n);
    end
  end

  // ---------------- stimulus helpers --------------------------------------
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Bit i of oc/tk holds out_clk/tick after the (i+1)-th edge.
  task automatic capture(input int n, output logic [15:0] oc, output logic [15:0] tk,
                         output int acks);
    oc = '0; tk = '0; acks = 0;
    for (int i = 0; i < n; i++) begin
      cyc(1);
      oc[i] = out_clk;
      tk[i] = tick;
      acks += int'(load_ack);
    end
  endtask

  logic [15:0] oc;
  logic [15:0] tk;
  int          acks;
  int          a2;

  initial begin
    rst = 1'b0; en = 1'b0; sync_clr = 1'b0; div_val = '0; div_load = 1'b0;

    // 1: reset, then N=2 waveform
    cyc(3);
    rst = 1'b1; en = 1'b1;
    chk_on = 1;
    check("t1_rst_out_clk", int'(out_clk), 0);
    check("t1_rst_tick", int'(tick), 0);
    check("t1_rst_cur_div", int'(cur_div), 2);
    check("t1_rst_ack", int'(load_ack), 0);
    capture(4, oc, tk, acks);
    check("t1_out_seq", int'(oc), 'b0101);
    check("t1_tick_seq", int'(tk), 'b0101);

    // 2: load 5 mid-period; N=2 period finishes first
    div_val = 8'd5; div_load = 1'b1;
    cyc(1);
    div_load = 1'b0;
    check("t2_still_n2", int'(cur_div), 2);
    check("t2_no_ack_yet", int'(load_ack), 0);
    cyc(1);
    check("t2_cur_div", int'(cur_div), 5);
    check("t2_ack", int'(load_ack), 1);
    capture(10, oc, tk, acks);
    check("t2_out_seq", int'(oc), 'b0110001100);
    check("t2_tick_seq", int'(tk), 'b0100001000);
    check("t2_ack_once", acks, 0);

    // 3: load 7 then 3 before the wrap -> single ack, N=3; then load 0 -> N=1
    div_val = 8'd7; div_load = 1'b1;
    cyc(1);
    a2 = int'(load_ack);
    div_val = 8'd3;
    cyc(1);
    a2 += int'(load_ack);
    div_load = 1'b0;
    capture(6, oc, tk, acks);
    check("t3_single_ack", acks + a2, 1);
    check("t3_cur_div", int'(cur_div), 3);
    div_val = 8'd0; div_load = 1'b1;
    cyc(1);
    div_load = 1'b0;
    cyc(4);
    check("t3_zero_is_one", int'(cur_div), 1);
    capture(5, oc, tk, acks);
    check("t3_n1_out", int'(oc), 'b00000);
    check("t3_n1_tick", int'(tk), 'b11111);

    // 4: N=6 (bypass at an N=1 wrap), freeze at cnt=4 for 10 cycles
    div_val = 8'd6; div_load = 1'b1;
    cyc(1);
    div_load = 1'b0;
    check("t4_bypass_ack", int'(load_ack), 1);
    check("t4_cur_div", int'(cur_div), 6);
    cyc(4);
    check("t4_out_at_cnt4", int'(out_clk), 1);
    en = 1'b0;
    capture(10, oc, tk, acks);
    check("t4_frozen_out", int'(oc), 'h3FF);
    check("t4_frozen_tick", int'(tk), 0);
    en = 1'b1;
    capture(2, oc, tk, acks);
    check("t4_resume_out", int'(oc), 'b01);
    check("t4_resume_tick", int'(tk), 'b01);

    // 5: N=4, sync_clr at cnt=2 together with a load of 9
    div_val = 8'd4; div_load = 1'b1;
    cyc(1);
    div_load = 1'b0;
    cyc(5);
    check("t5_cur_div4", int'(cur_div), 4);
    cyc(2);
    check("t5_out_at_cnt2", int'(out_clk), 1);
    sync_clr = 1'b1; div_val = 8'd9; div_load = 1'b1;
    cyc(1);
    sync_clr = 1'b0; div_load = 1'b0;
    check("t5_clr_out", int'(out_clk), 0);
    check("t5_clr_tick", int'(tick), 0);
    check("t5_clr_cur_div", int'(cur_div), 9);
    check("t5_clr_ack", int'(load_ack), 1);
    capture(9, oc, tk, acks);
    check("t5_n9_out", int'(oc), 'b011110000);
    check("t5_n9_tick", int'(tk), 'b010000000);

    // 6: short async reset mid-period with N=5 active and 7 pending
    div_val = 8'd5; div_load = 1'b1;
    cyc(1);
    div_load = 1'b0;
    cyc(8);
    check("t6_cur_div5", int'(cur_div), 5);
    cyc(3);
    check("t6_out_before", int'(out_clk), 1);
    div_val = 8'd7; div_load = 1'b1;
    cyc(1);
    div_load = 1'b0;
    check("t6_tick_before", int'(tick), 1);
    #2 rst = 1'b0;
    #1;
    check("t6_rst_out", int'(out_clk), 0);
    check("t6_rst_tick", int'(tick), 0);
    check("t6_rst_cur_div", int'(cur_div), 2);
    check("t6_rst_ack", int'(load_ack), 0);
    #2 rst = 1'b1;
    capture(12, oc, tk, acks);
    check("t6_pending_dropped", acks, 0);
    check("t6_n2_out", int'(oc), 'b010101010101);
    check("t6_final_cur_div", int'(cur_div), 2);

    chk_on = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
